// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg: shared types and constants for the data-memory burst sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  // {CEN, WEN, OEN} with the memory fully deselected
  localparam logic [2:0] CTRL_IDLE = 3'b111;

endpackage

`default_nettype wire

// File: rtl/rd_capture_pipe.sv
// ---------------------------------------------------------------------------
// rd_capture_pipe: RD_LAT-deep valid + beat-index delay line for load capture
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rd_capture_pipe #(
  parameter int RD_LAT = 0,
  parameter int IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);

  generate
    if (RD_LAT == 0) begin : g_passthru
      assign vld_o = vld_i;
      assign idx_o = idx_i;
    end else begin : g_delay
      logic [RD_LAT-1:0]            vld_q;
      logic [RD_LAT-1:0][IDX_W-1:0] idx_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_q <= '0;
          idx_q <= '0;
        end else begin
          vld_q[0] <= vld_i;
          idx_q[0] <= idx_i;
          for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
          end
        end
      end

      assign vld_o = vld_q[RD_LAT-1];
      assign idx_o = idx_q[RD_LAT-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_burst_sequencer.sv
// ---------------------------------------------------------------------------
// mem_burst_sequencer: N-beat load/store burst engine for the data memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_burst_sequencer
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int MAX_BEATS = 4,
  parameter int RD_LAT    = 0,
  parameter int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  input  logic                        req_write,
  input  logic [31:0]                 req_addr,
  input  logic [BEAT_W-1:0]           req_beats,
  input  logic [WORD_W*MAX_BEATS-1:0] req_wdata,
  output logic                        stall,
  output logic                        rsp_valid,
  output logic                        rsp_err,
  output logic [WORD_W*MAX_BEATS-1:0] rsp_rdata,
  output logic                        CEN,
  output logic                        WEN,
  output logic                        OEN,
  output logic [ADDR_W-1:0]           A,
  output logic [WORD_W-1:0]           Data2Mem,
  input  logic [WORD_W-1:0]           ReadDataMem
);

  localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [1:0] DRAIN_LAST = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef logic [MAX_BEATS-1:0][WORD_W-1:0] beats_t;

  state_e            state_q, state_d;
  logic              write_q;
  logic [ADDR_W-1:0] base_q;
  logic [BEAT_W-1:0] beats_q;
  logic [BEAT_W-1:0] cnt_q;
  logic [1:0]        drain_q;
  beats_t            wdata_q;
  beats_t            rdata_q;

  logic              req_bad;
  logic              last_beat;
  logic [IDX_W-1:0]  cnt_idx;
  logic              issue_rd;
  logic              cap_vld;
  logic [IDX_W-1:0]  cap_idx;

  assign req_bad   = (req_addr[1:0] != 2'b00) || (req_beats == '0) ||
                     (req_beats > BEAT_W'(MAX_BEATS));
  assign last_beat = (cnt_q == beats_q - 1'b1);
  assign cnt_idx   = cnt_q[IDX_W-1:0];
  assign issue_rd  = (state_q == ISSUE) && !write_q;

  rd_capture_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_rd_capture_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (issue_rd),
    .idx_i (cnt_idx),
    .vld_o (cap_vld),
    .idx_o (cap_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid) state_d = req_bad ? ERR : ISSUE;
      ISSUE: if (last_beat) state_d = (write_q || RD_LAT == 0) ? DONE : DRAIN;
      DRAIN: if (drain_q == DRAIN_LAST) state_d = DONE;
      DONE:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    {CEN, WEN, OEN} = CTRL_IDLE;
    A               = '0;
    Data2Mem        = '0;
    rsp_valid       = 1'b0;
    rsp_err         = 1'b0;
    case (state_q)
      ISSUE: begin
        CEN = 1'b0;
        A   = base_q + ADDR_W'(cnt_q);
        if (write_q) begin
          WEN      = 1'b0;
          Data2Mem = wdata_q[cnt_idx];
        end else begin
          OEN = 1'b0;
        end
      end
      DONE: rsp_valid = 1'b1;
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  // Captured request fields; req_* are not looked at again until the next IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      base_q  <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && !req_bad) begin
            write_q <= req_write;
            base_q  <= req_addr[ADDR_W+1:2];
            beats_q <= req_beats;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            drain_q <= '0;
            rdata_q <= '0;
          end
        end
        ISSUE:   cnt_q   <= cnt_q + 1'b1;
        DRAIN:   drain_q <= drain_q + 1'b1;
        default: ;
      endcase
      if (cap_vld) rdata_q[cap_idx] <= ReadDataMem;
    end
  end

  assign stall     = req_valid & ~rsp_valid;
  assign rsp_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_sequencer: directed self-checking bench, RD_LAT=0 and RD_LAT=2
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_burst_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   req_valid = 2'b00;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr  = '0;
  logic [2:0]   req_beats = '0;
  logic [127:0] req_wdata = '0;

  logic         stall0, rsp_valid0, rsp_err0, cen0, wen0, oen0;
  logic [127:0] rdata0;
  logic [6:0]   a0;
  logic [31:0]  d0, rd0;
  logic         stall2, rsp_valid2, rsp_err2, cen2, wen2, oen2;
  logic [127:0] rdata2;
  logic [6:0]   a2;
  logic [31:0]  d2, rd2;

  mem_burst_sequencer #(.ADDR_W(7), .MAX_BEATS(4), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_write(req_write),
    .req_addr(req_addr), .req_beats(req_beats), .req_wdata(req_wdata),
    .stall(stall0), .rsp_valid(rsp_valid0), .rsp_err(rsp_err0), .rsp_rdata(rdata0),
    .CEN(cen0), .WEN(wen0), .OEN(oen0), .A(a0), .Data2Mem(d0), .ReadDataMem(rd0)
  );

  mem_burst_sequencer #(.ADDR_W(7), .MAX_BEATS(4), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_write(req_write),
    .req_addr(req_addr), .req_beats(req_beats), .req_wdata(req_wdata),
    .stall(stall2), .rsp_valid(rsp_valid2), .rsp_err(rsp_err2), .rsp_rdata(rdata2),
    .CEN(cen2), .WEN(wen2), .OEN(oen2), .A(a2), .Data2Mem(d2), .ReadDataMem(rd2)
  );

  // Memory models: zero-latency read for dut0, two-cycle registered read for dut2
  logic [31:0] mem0 [128];
  logic [31:0] mem2 [128];
  logic [31:0] p1 = '0, p2 = '0;

  always @(posedge clk) if (!cen0 && !wen0) mem0[a0] = d0;
  assign rd0 = mem0[a0];
  always @(posedge clk) begin
    p1 <= mem2[a2];
    p2 <= p1;
  end
  assign rd2 = p2;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit           sel;
  logic         o_stall, o_rsp, o_err, o_cen, o_wen, o_oen;
  logic [127:0] o_rdata;
  logic [6:0]   o_a;
  logic [31:0]  o_d;
  assign o_stall = sel ? stall2     : stall0;
  assign o_rsp   = sel ? rsp_valid2 : rsp_valid0;
  assign o_err   = sel ? rsp_err2   : rsp_err0;
  assign o_rdata = sel ? rdata2     : rdata0;
  assign o_cen   = sel ? cen2       : cen0;
  assign o_wen   = sel ? wen2       : wen0;
  assign o_oen   = sel ? oen2       : oen0;
  assign o_a     = sel ? a2         : a0;
  assign o_d     = sel ? d2         : d0;

  // Results of the last do_req; cycle numbers are relative to t0
  int           rsp_cyc, nacc, stall_cnt;
  logic         r_err, r_stall_at_rsp;
  logic [127:0] r_rdata, d_pack;
  logic [63:0]  a_pack;
  logic [15:0]  ctl_pack;

  task automatic do_req(input bit s, input logic wr, input logic [31:0] addr,
                        input logic [2:0] beats, input logic [127:0] wd);
    @(negedge clk);
    sel       = s;
    req_write = wr;
    req_addr  = addr;
    req_beats = beats;
    req_wdata = wd;
    req_valid = s ? 2'b10 : 2'b01;
    rsp_cyc = -1; nacc = 0; stall_cnt = 0;
    r_err = 1'bx; r_stall_at_rsp = 1'bx; r_rdata = 'x;
    a_pack = '0; d_pack = '0; ctl_pack = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (o_rsp) begin
        rsp_cyc        = c;
        r_err          = o_err;
        r_rdata        = o_rdata;
        r_stall_at_rsp = o_stall;
        break;
      end
      if (o_stall) stall_cnt++;
      if (!o_cen) begin
        nacc++;
        a_pack   = (a_pack << 8) | 64'(o_a);
        d_pack   = (d_pack << 32) | 128'(o_d);
        ctl_pack = (ctl_pack << 3) | 16'({o_cen, o_wen, o_oen});
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  int pulses;

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem0[i] = '0;
      mem2[i] = '0;
    end
    mem0[16]  = 32'hDEADBEEF;
    mem0[17]  = 32'h3FF00000;
    mem0[127] = 32'hA1A1A1A1;
    mem0[0]   = 32'hB2B2B2B2;
    mem0[1]   = 32'hC3C3C3C3;
    for (int i = 0; i < 4; i++) mem2[20+i] = 32'h11111111 * (i + 1);

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 128'(rsp_valid0), 128'd0);
    chk("reset_ctrl", 128'({cen0, wen0, oen0, cen2, wen2, oen2}), 128'h3F);
    chk("reset_addr", 128'({a0, a2}), 128'd0);
    chk("reset_rdata", rdata0 | rdata2, 128'd0);
    rst_n = 1'b1;

    // Two-beat load, zero read latency
    do_req(0, 1'b0, 32'h40, 3'd2, '0);
    chk("ld2_latency", 128'(rsp_cyc), 128'd3);
    chk("ld2_err", 128'(r_err), 128'd0);
    chk("ld2_addr", 128'(a_pack), 128'h1011);
    chk("ld2_ctrl", 128'(ctl_pack), 128'o22);
    chk("ld2_rdata", r_rdata, {64'd0, 32'h3FF00000, 32'hDEADBEEF});
    chk("ld2_stall_cycles", 128'(stall_cnt), 128'd3);
    chk("ld2_stall_at_rsp", 128'(r_stall_at_rsp), 128'd0);

    // Four-beat store, presented back-to-back after the previous DONE
    do_req(0, 1'b1, 32'h10, 3'd4, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("st4_latency", 128'(rsp_cyc), 128'd5);
    chk("st4_err", 128'(r_err), 128'd0);
    chk("st4_addr", 128'(a_pack), 128'h04050607);
    chk("st4_ctrl", 128'(ctl_pack), 128'o1111);
    chk("st4_data", d_pack, {32'd1, 32'd2, 32'd3, 32'd4});
    chk("st4_mem", {mem0[7], mem0[6], mem0[5], mem0[4]}, {32'd4, 32'd3, 32'd2, 32'd1});

    do_req(0, 1'b0, 32'h10, 3'd4, '0);
    chk("st4_readback", r_rdata, {32'd4, 32'd3, 32'd2, 32'd1});

    // Rejected requests
    do_req(0, 1'b0, 32'h42, 3'd1, '0);
    chk("err_misalign", {96'(rsp_cyc), 16'(nacc), 16'(r_err)}, {96'd1, 16'd0, 16'd1});
    do_req(0, 1'b1, 32'h40, 3'd0, '0);
    chk("err_zero_beats", {96'(rsp_cyc), 16'(nacc), 16'(r_err)}, {96'd1, 16'd0, 16'd1});
    do_req(0, 1'b0, 32'h40, 3'd5, '0);
    chk("err_too_many", {96'(rsp_cyc), 16'(nacc), 16'(r_err)}, {96'd1, 16'd0, 16'd1});

    // Address wrap at the top of the word space
    do_req(0, 1'b0, 32'h1FC, 3'd3, '0);
    chk("wrap_latency", 128'(rsp_cyc), 128'd4);
    chk("wrap_addr", 128'(a_pack), 128'h7F0001);
    chk("wrap_rdata", r_rdata, {32'd0, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1});

    // Two-cycle read latency
    do_req(1, 1'b0, 32'h50, 3'd4, '0);
    chk("lat2_latency", 128'(rsp_cyc), 128'd7);
    chk("lat2_addr", 128'(a_pack), 128'h14151617);
    chk("lat2_ctrl", 128'(ctl_pack), 128'o2222);
    chk("lat2_rdata", r_rdata, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});

    // Reset in the middle of a four-beat store
    @(negedge clk);
    sel = 0;
    req_write = 1'b1; req_addr = 32'h20; req_beats = 3'd4;
    req_wdata = {32'd8, 32'd7, 32'd6, 32'd5};
    req_valid = 2'b01;
    repeat (3) @(negedge clk);
    chk("abort_beat2", 128'({cen0, a0}), 128'({1'b0, 7'd10}));
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", 128'({cen0, wen0, oen0, rsp_valid0}), 128'b1110);
    rst_n = 1'b1;
    req_valid = 2'b00;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid0) pulses++;
    end
    chk("abort_no_rsp", 128'(pulses), 128'd0);

    do_req(0, 1'b0, 32'h40, 3'd2, '0);
    chk("post_abort_latency", 128'(rsp_cyc), 128'd3);
    chk("post_abort_rdata", r_rdata, {64'd0, 32'h3FF00000, 32'hDEADBEEF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
